regular_bin_sequencer: RTL
==========================

Name: regular_bin_sequencer

Overview:
Sequencer that owns the arithmetic-decoder state (m_range, m_value) and drives the combinational regular-bin decode datapath once per bin request.
Per request it reads the context state, presents range/value/pState to the datapath, and latches the next range/value. It refills value LSBs from the bitstream after renormalisation and writes back the updated context state.
It sits between the syntax-element parser (requester), the context memory and the bitstream reader.

Parameters:
CTX_ADDR_W, 6, context memory address width
BIN_W, 4, width of the decoded bin bus from the datapath
IDX_MAX, 62, saturation limit of the 7-bit probability index in pState[6:0]

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
init_valid  in  1  load decoder state
init_value  in  16  initial m_value
bin_req  in  1  parser requests one regular bin
bin_ctx  in  CTX_ADDR_W  context index for the request
bin_ready  out  1  request accepted when bin_req&bin_ready
bin_valid  out  1  one-cycle pulse, bin_out valid
bin_out  out  BIN_W  decoded bin
ctx_rd_en  out  1  context read strobe, data returned next cycle
ctx_addr  out  CTX_ADDR_W  context read/write address
ctx_rd_data  in  8  pState {mps, idx[6:0]}
ctx_wr_en  out  1  context write strobe
ctx_wr_data  out  8  updated pState
dp_range  out  9  m_range to datapath
dp_value  out  16  m_value to datapath
dp_pstate  out  8  pState to datapath
dp_bin  in  BIN_W  datapath bin
dp_lps  in  1  1 = LPS path taken
dp_mps_renorm  in  1  1 = datapath shifted value on MPS path
dp_numbits  in  3  shift amount applied by datapath
dp_range_nx  in  9  next range
dp_value_nx  in  16  next value (LSBs zero-filled)
bits_req  out  1  request bits_num bitstream bits
bits_num  out  3  number of bits requested (1..6)
bits_valid  in  1  bits_data valid
bits_data  in  6  right-aligned bitstream bits

Behaviour:
- Reset (async, any state): FSM=IDLE; range=0, value=0, initialized=0. All outputs 0: bin_ready, bin_valid, bin_out, ctx_rd_en, ctx_wr_en, ctx_addr, ctx_wr_data, bits_req, bits_num, dp_*.
- dp_range/dp_value are driven continuously from the range/value registers; dp_pstate comes from the latched context register.
- FSM states: IDLE, READY, CTX_RD, DECODE, REFILL, WB.
- IDLE:
  - init_valid -> range=510, value=init_value, go READY next cycle.
  - bin_ready=0.
- READY:
  - bin_ready=1.
  - init_valid has priority over bin_req: re-init, stay READY, request not accepted.
  - Else bin_req: latch bin_ctx, go CTX_RD.
- CTX_RD: ctx_rd_en=1, ctx_addr=latched ctx; go DECODE.
- DECODE:
  - Latch ctx_rd_data into pState register at the cycle start; the datapath sees it combinationally.
  - At the end of the cycle, capture dp_bin, dp_lps, dp_numbits; range<=dp_range_nx, value<=dp_value_nx.
  - If (dp_lps|dp_mps_renorm) and dp_numbits!=0, go REFILL; else go WB.
- REFILL:
  - bits_req=1, bits_num=captured numbits; hold until bits_valid.
  - On bits_valid: value <= value | (bits_data & ((1<<numbits)-1)); go WB.
  - bits_data bits above numbits are ignored.
- WB:
  - ctx_wr_en=1, ctx_addr=latched ctx.
  - bin_valid=1, bin_out=captured bin.
  - Go READY.
- Context update rule, with pState={mps,idx}:
  - MPS path: idx' = (idx>=IDX_MAX) ? idx : idx+1; mps unchanged.
  - LPS path, idx==0: mps' = ~mps, idx' = 0.
  - LPS path, otherwise: idx' = idx>>1.
- Latency: request accept to bin_valid is 3 cycles with no refill (CTX_RD, DECODE, WB). With refill, add 1 cycle plus bits_valid wait.
- Throughput: one bin per 4 cycles minimum. bin_ready=0 outside READY.
- Hazards:
  - WB precedes the next CTX_RD, so back-to-back requests to the same context see the updated state; no forwarding is needed.
  - Context write and read never coincide.
- init_valid outside IDLE/READY is ignored.
- bin_req in IDLE is never accepted.
- bits_valid outside REFILL is ignored.
- Reset mid-operation (e.g. in REFILL) abandons the bin: no ctx write and no bin_valid. Init is required before the next request.

Test Plan:
- Reset, then init_valid with init_value=0x1234 -> next cycle dp_range=510, dp_value=0x1234, bin_ready=1; bin_req held during IDLE is never accepted.
- bin_req ctx=5, memory[5]=0x8A, model returns lps=0, mps_renorm=0, numbits=0, range_nx=400, bin=1 -> bin_valid 3 cycles after accept, bin_out=1, ctx write 0x8B to addr 5, dp_range=400, no bits_req.
- ctx=7 holding 0x81, lps=1, numbits=3, value_nx=0x4000, bits_valid delayed 2 cycles with bits_data=6'b111101 -> bits_num=3 held, value=0x4005, ctx write 0x80, bin_valid one cycle after bits_valid.
- LPS on context 0x80 -> ctx write 0x00 (MPS flip); MPS on 0xBE (idx 62) -> ctx write 0xBE (saturation).
- Two back-to-back requests to ctx 3 (initial 0x10, both MPS) -> second DECODE sees dp_pstate=0x11, final write 0x12.
- Assert rst during REFILL -> all outputs 0 immediately, no ctx_wr_en, no bin_valid; bin_ready stays 0 until a new init_valid.

Source files
------------

// File: rtl/regular_bin_sequencer.sv
// Regular-bin decode sequencer.
// This block owns the arithmetic-decoder state (m_range, m_value) and steps
// the external combinational regular-bin datapath once per accepted request:
// context read -> decode -> optional bitstream refill -> context write-back.
module regular_bin_sequencer #(
  parameter int CTX_ADDR_W = 6,
  parameter int BIN_W      = 4,
  parameter int IDX_MAX    = 62
) (
  input  logic                  clk,
  input  logic                  rst,
  // decoder initialisation
  input  logic                  init_valid,
  input  logic [15:0]           init_value,
  // parser request / response
  input  logic                  bin_req,
  input  logic [CTX_ADDR_W-1:0] bin_ctx,
  output logic                  bin_ready,
  output logic                  bin_valid,
  output logic [BIN_W-1:0]      bin_out,
  // context memory
  output logic                  ctx_rd_en,
  output logic [CTX_ADDR_W-1:0] ctx_addr,
  input  logic [7:0]            ctx_rd_data,
  output logic                  ctx_wr_en,
  output logic [7:0]            ctx_wr_data,
  // decode datapath
  output logic [8:0]            dp_range,
  output logic [15:0]           dp_value,
  output logic [7:0]            dp_pstate,
  input  logic [BIN_W-1:0]      dp_bin,
  input  logic                  dp_lps,
  input  logic                  dp_mps_renorm,
  input  logic [2:0]            dp_numbits,
  input  logic [8:0]            dp_range_nx,
  input  logic [15:0]           dp_value_nx,
  // bitstream reader
  output logic                  bits_req,
  output logic [2:0]            bits_num,
  input  logic                  bits_valid,
  input  logic [5:0]            bits_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READY  = 3'd1;
  localparam logic [2:0] S_CTX_RD = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_REFILL = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [8:0] RANGE_INIT = 9'd510;
  localparam logic [6:0] IDX_LIM    = 7'(IDX_MAX);

  logic [2:0]            state_q,   state_d;
  logic [8:0]            range_q,   range_d;
  logic [15:0]           value_q,   value_d;
  logic [CTX_ADDR_W-1:0] ctx_q,     ctx_d;
  logic [7:0]            pstate_q,  pstate_d;
  logic [BIN_W-1:0]      bin_q,     bin_d;
  logic                  lps_q,     lps_d;
  logic [2:0]            numbits_q, numbits_d;

  logic [5:0]            refill_mask;
  logic [6:0]            idx_cur;
  logic [6:0]            idx_nx;
  logic                  mps_nx;
  logic [7:0]            pstate_nx;

  // Mask keeping only the low numbits_q bits of the refill data.
  always_comb begin
    refill_mask = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      refill_mask[i] = (3'(i) < numbits_q);
    end
  end

  // Probability-state update applied at write-back.
  always_comb begin
    idx_cur = pstate_q[6:0];
    idx_nx  = idx_cur;
    mps_nx  = pstate_q[7];
    if (!lps_q) begin
      if (idx_cur < IDX_LIM) begin
        idx_nx = 7'(idx_cur + 7'd1);
      end
    end else if (idx_cur == 7'd0) begin
      mps_nx = ~pstate_q[7];
      idx_nx = '0;
    end else begin
      idx_nx = idx_cur >> 1;
    end
    pstate_nx = {mps_nx, idx_nx};
  end

  // Next-state logic for the FSM and the decoder / capture registers.
  always_comb begin
    state_d   = state_q;
    range_d   = range_q;
    value_d   = value_q;
    ctx_d     = ctx_q;
    pstate_d  = pstate_q;
    bin_d     = bin_q;
    lps_d     = lps_q;
    numbits_d = numbits_q;
    case (state_q)
      S_IDLE: begin
        if (init_valid) begin
          range_d = RANGE_INIT;
          value_d = init_value;
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (init_valid) begin
          range_d = RANGE_INIT;
          value_d = init_value;
        end else if (bin_req) begin
          ctx_d   = bin_ctx;
          state_d = S_CTX_RD;
        end
      end
      S_CTX_RD: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        pstate_d  = ctx_rd_data;
        bin_d     = dp_bin;
        lps_d     = dp_lps;
        numbits_d = dp_numbits;
        range_d   = dp_range_nx;
        value_d   = dp_value_nx;
        if ((dp_lps || dp_mps_renorm) && (dp_numbits != 3'd0)) begin
          state_d = S_REFILL;
        end else begin
          state_d = S_WB;
        end
      end
      S_REFILL: begin
        if (bits_valid) begin
          value_d = value_q | {10'd0, bits_data & refill_mask};
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any bin in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      range_q   <= '0;
      value_q   <= '0;
      ctx_q     <= '0;
      pstate_q  <= '0;
      bin_q     <= '0;
      lps_q     <= 1'b0;
      numbits_q <= '0;
    end else begin
      state_q   <= state_d;
      range_q   <= range_d;
      value_q   <= value_d;
      ctx_q     <= ctx_d;
      pstate_q  <= pstate_d;
      bin_q     <= bin_d;
      lps_q     <= lps_d;
      numbits_q <= numbits_d;
    end
  end

  // Output decode; everything idles at zero outside its owning state.
  always_comb begin
    bin_ready   = (state_q == S_READY);
    ctx_rd_en   = (state_q == S_CTX_RD);
    ctx_wr_en   = (state_q == S_WB);
    bin_valid   = (state_q == S_WB);
    bits_req    = (state_q == S_REFILL);
    ctx_addr    = ((state_q == S_CTX_RD) || (state_q == S_WB)) ? ctx_q : '0;
    bin_out     = (state_q == S_WB) ? bin_q : '0;
    ctx_wr_data = (state_q == S_WB) ? pstate_nx : '0;
    bits_num    = (state_q == S_REFILL) ? numbits_q : '0;
    dp_range    = range_q;
    dp_value    = value_q;
    // read data arrives during DECODE; forward it so the datapath needs no extra cycle
    dp_pstate   = (state_q == S_DECODE) ? ctx_rd_data : pstate_q;
  end

endmodule
